// File: rtl/nano_mem_responder_if.sv
// -----------------------------------------------------------------------------
// nano_mem_responder_if
// Bus bundle between the host loader / NanoCPU side (master) and the memory
// responder (slave).
//   CPU port   : address, dataW, ce, we (master -> slave), dataR (slave -> master)
//   Loader port: ld_valid, ld_data, ld_last (master -> slave), ld_ready (slave -> master)
// -----------------------------------------------------------------------------
interface nano_mem_responder_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] address;
    logic [15:0]       dataW;
    logic [15:0]       dataR;
    logic              ce;
    logic              we;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_last;
    logic              ld_ready;

    modport master (
        output address, dataW, ce, we, ld_valid, ld_data, ld_last,
        input  dataR, ld_ready
    );

    modport slave (
        input  address, dataW, ce, we, ld_valid, ld_data, ld_last,
        output dataR, ld_ready
    );
endinterface

// File: rtl/nano_mem_responder.sv
// -----------------------------------------------------------------------------
// nano_mem_responder
// 256 x 16-bit word store serving the NanoCPU memory port, with a boot loader
// that fills memory from a byte stream (big-endian pairs) while holding the CPU
// in reset, then releases it.
//
// Ports:
//   ck        clock, rising edge
//   rst       asynchronous active-low reset
//   bus       nano_mem_responder_if.slave (CPU port + loader stream)
//   cpu_rst   active-high reset to the NanoCPU
//   load_done image loaded, CPU running
//   wr_err    one-cycle pulse after a discarded protected CPU write
//
// Build option: MEM_WRPROT_EN -- when defined, CPU writes below PROT_TOP are
// discarded and flagged on wr_err; when undefined wr_err is tied low.
//
// state   | meaning
// --------+--------------------------------------------------------------
// WAIT_HI | waiting for high byte of next word (ld_last ignored)
// WAIT_LO | waiting for low byte; writes word, advances pointer
// RELEASE | one-cycle gap, loader closed, CPU still in reset
// RUN     | CPU released, CPU port live, loader ignored until reset
// -----------------------------------------------------------------------------
module nano_mem_responder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
`ifdef MEM_WRPROT_EN
    ,
    parameter logic [ADDR_W-1:0] PROT_TOP = 8'h40
`endif
) (
    input  logic                    ck,
    input  logic                    rst,
    nano_mem_responder_if.slave     bus,
    output logic                    cpu_rst,
    output logic                    load_done,
    output logic                    wr_err
);

    localparam logic [1:0] WAIT_HI = 2'd0;
    localparam logic [1:0] WAIT_LO = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] RUN     = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state_q,   state_d;
    logic [ADDR_W-1:0] ld_ptr_q,  ld_ptr_d;
    logic [7:0]        hi_byte_q, hi_byte_d;

    logic [15:0]       mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    logic              ld_accept;
    logic              cpu_wr;
    logic              prot_hit;

    assign bus.ld_ready = (state_q == WAIT_HI) || (state_q == WAIT_LO);
    assign ld_accept    = bus.ld_valid && bus.ld_ready;
    assign cpu_rst      = (state_q != RUN);
    assign load_done    = (state_q == RUN);
    assign cpu_wr       = (state_q == RUN) && bus.ce && bus.we;

    // Zero-wait-state read: the CPU latches dataR in the same state that
    // drives the address, so this path must stay combinational.
    assign bus.dataR = ((state_q == RUN) && bus.ce) ? mem[bus.address] : 16'h0000;

`ifdef MEM_WRPROT_EN
    logic wr_err_q, wr_err_d;

    assign prot_hit = (bus.address < PROT_TOP);
    assign wr_err_d = cpu_wr && prot_hit;
    assign wr_err   = wr_err_q;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end
`else
    assign prot_hit = 1'b0;
    assign wr_err   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ld_ptr_d  = ld_ptr_q;
        hi_byte_d = hi_byte_q;
        mem_we    = 1'b0;
        mem_addr  = ld_ptr_q;
        mem_wdata = {hi_byte_q, bus.ld_data};

        case (state_q)
            WAIT_HI: begin
                if (ld_accept) begin
                    hi_byte_d = bus.ld_data;
                    state_d   = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (ld_accept) begin
                    mem_we   = 1'b1;
                    ld_ptr_d = ld_ptr_q + 1'b1;
                    // The last address ends the image even without ld_last,
                    // so the pointer wrap never overwrites word 0.
                    if (bus.ld_last || (ld_ptr_q == LAST_PTR)) begin
                        state_d = RELEASE;
                    end else begin
                        state_d = WAIT_HI;
                    end
                end
            end
            RELEASE: begin
                state_d = RUN;
            end
            RUN: begin
                mem_addr  = bus.address;
                mem_wdata = bus.dataW;
                mem_we    = cpu_wr && !prot_hit;
            end
            default: begin
                state_d = WAIT_HI;
            end
        endcase
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q   <= WAIT_HI;
            ld_ptr_q  <= '0;
            hi_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            ld_ptr_q  <= ld_ptr_d;
            hi_byte_q <= hi_byte_d;
        end
    end

    // Storage is deliberately not reset: contents survive a reset.
    always_ff @(posedge ck) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_nano_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_nano_mem_responder
// Scoreboard bench: stimulus pushes expected dataR values into a queue, a
// negedge monitor pops and compares whenever ce is presented. Loaded images are
// predicted from byte positions in the issued stream.
// -----------------------------------------------------------------------------
module tb_nano_mem_responder;

    localparam int DEPTH = 256;

    logic ck    = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_rst;
    logic load_done;
    logic wr_err;

    nano_mem_responder_if bus ();

    nano_mem_responder dut (
        .ck        (ck),
        .rst       (rst_n),
        .bus       (bus),
        .cpu_rst   (cpu_rst),
        .load_done (load_done),
        .wr_err    (wr_err)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [15:0] val;
        bit          known;
        logic [7:0]  addr;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] ref_mem [DEPTH];
    bit          ref_vld [DEPTH];
    bit          in_run  = 1'b0;
    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [7:0]  stim_b [$];
    bit          stim_l [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_prot(input logic [7:0] a);
`ifdef MEM_WRPROT_EN
        return (a < 8'h40);
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard monitor
    always @(negedge ck) begin
        if (rst_n && bus.ce) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: dataR=%h presented with no expected entry", bus.dataR);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.known) chk($sformatf("dataR[%0h]", mon_e.addr), 32'(bus.dataR), 32'(mon_e.val));
            end
        end
    end

    // All tasks below are entered and left 1 time unit after a rising edge.
    task automatic push_exp(input logic [7:0] a);
        exp_t e;
        e.addr  = a;
        e.val   = in_run ? ref_mem[a] : 16'h0000;
        e.known = in_run ? ref_vld[a] : 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic cpu_read(input logic [7:0] a);
        bus.ce = 1'b1; bus.we = 1'b0; bus.address = a;
        push_exp(a);
        @(posedge ck); #1;
        bus.ce = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
        bit exp_err;
        bus.ce = 1'b1; bus.we = 1'b1; bus.address = a; bus.dataW = d;
        push_exp(a);
        exp_err = in_run && is_prot(a);
        @(posedge ck); #1;
        bus.ce = 1'b0; bus.we = 1'b0;
        if (in_run && !is_prot(a)) begin
            ref_mem[a] = d;
            ref_vld[a] = 1'b1;
        end
        chk($sformatf("wr_err_after_write[%0h]", a), 32'(wr_err), 32'(exp_err));
        if (exp_err) begin
            @(posedge ck); #1;
            chk("wr_err_single_cycle", 32'(wr_err), 32'(0));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int gap, output bit ok);
        bus.ld_valid = 1'b0;
        repeat (gap) begin @(posedge ck); #1; end
        bus.ld_valid = 1'b1; bus.ld_data = b; bus.ld_last = last;
        ok = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            if (bus.ld_ready) ok = 1'b1;
            @(posedge ck); #1;
        end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    endtask

    // Byte k belongs to word k/2 (even k = high half). The image ends at the
    // first low byte flagged last, or at the 256th word.
    task automatic model_image(output int n, output bit complete);
        n = stim_b.size();
        complete = 1'b0;
        for (int k = 1; k < stim_b.size(); k += 2) begin
            ref_mem[k/2] = {stim_b[k-1], stim_b[k]};
            ref_vld[k/2] = 1'b1;
            if (stim_l[k] || (k/2 == DEPTH - 1)) begin
                n = k + 1;
                complete = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_stream(input string name, input int max_gap);
        int exp_n, acc;
        bit complete, ok;
        model_image(exp_n, complete);
        acc = 0;
        for (int k = 0; k < stim_b.size(); k++) begin
            send_byte(stim_b[k], stim_l[k], $urandom_range(0, max_gap), ok);
            if (!ok) break;
            acc++;
            if (complete && acc == exp_n) begin
                chk({name, "_release_cpu_rst"},   32'(cpu_rst),      32'(1));
                chk({name, "_release_ld_ready"},  32'(bus.ld_ready), 32'(0));
                chk({name, "_release_load_done"}, 32'(load_done),    32'(0));
                @(posedge ck); #1;
                chk({name, "_run_cpu_rst"},   32'(cpu_rst),      32'(0));
                chk({name, "_run_load_done"}, 32'(load_done),    32'(1));
                chk({name, "_run_ld_ready"},  32'(bus.ld_ready), 32'(0));
                in_run = 1'b1;
            end
        end
        chk({name, "_bytes_accepted"}, 32'(acc), 32'(exp_n));
    endtask

    task automatic do_reset(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        in_run = 1'b0;
        chk({name, "_cpu_rst_async"}, 32'(cpu_rst),      32'(1));
        chk({name, "_ld_ready"},      32'(bus.ld_ready), 32'(1));
        chk({name, "_load_done"},     32'(load_done),    32'(0));
        chk({name, "_wr_err"},        32'(wr_err),       32'(0));
        @(posedge ck); #1;
        rst_n = 1'b1;
    endtask

    task automatic set_stream1(input bit last_on_hi);
        stim_b = {8'h00, 8'h50, 8'h60, 8'h12, 8'h80, 8'h00};
        stim_l = {1'b0, 1'b0, last_on_hi, 1'b0, 1'b0, 1'b1};
    endtask

    initial begin
        bit ok;
        bus.address = '0; bus.dataW = '0; bus.ce = 1'b0; bus.we = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_vld[i] = 1'b0; end

        repeat (3) @(posedge ck);
        #1;
        chk("reset_cpu_rst",   32'(cpu_rst),      32'(1));
        chk("reset_ld_ready",  32'(bus.ld_ready), 32'(1));
        chk("reset_load_done", 32'(load_done),    32'(0));
        chk("reset_wr_err",    32'(wr_err),       32'(0));
        rst_n = 1'b1;
        cpu_read(8'h00);

        // Full 256-word image without ld_last; surplus bytes must be refused.
        stim_b.delete(); stim_l.delete();
        for (int i = 0; i < 600; i++) begin
            stim_b.push_back(8'($urandom_range(0, 255)));
            stim_l.push_back(1'b0);
        end
        load_stream("overflow", 1);
        for (int a = 0; a < DEPTH; a++) cpu_read(8'(a));
        send_byte(8'h5A, 1'b1, 0, ok);
        chk("run_ignores_loader", 32'(ok), 32'(0));

        // Basic image; reset lands in RUN, write during load is ignored.
        do_reset("reset_in_run");
        cpu_write(8'h05, 16'hDEAD);
        set_stream1(1'b0);
        load_stream("basic", 0);
        cpu_read(8'h00); cpu_read(8'h01); cpu_read(8'h02);
        cpu_read(8'h03); cpu_read(8'h05);

        // Write-then-read timing and ce gating.
        cpu_write(8'h21, 16'hBEEF);
        cpu_read(8'h21);
        bus.address = 8'h21; bus.ce = 1'b0;
        #1;
        chk("ce_low_dataR", 32'(bus.dataR), 32'(0));
        cpu_write(8'h10, 16'h1234);
        cpu_read(8'h10);
        cpu_write(8'h3F, 16'h3F3F);
        cpu_read(8'h3F);
        cpu_write(8'h40, 16'h1234);
        cpu_read(8'h40);
        for (int i = 0; i < 6; i++) begin
            logic [7:0]  a;
            logic [15:0] d;
            a = 8'($urandom_range(0, 255));
            d = 16'($urandom_range(0, 65535));
            cpu_write(a, d);
            cpu_read(a);
        end

        // Reset after three accepted bytes; reload must restart at word 0.
        do_reset("pre_partial");
        stim_b = {8'h11, 8'h22, 8'h33};
        stim_l = {1'b0, 1'b0, 1'b0};
        load_stream("partial", 0);
        do_reset("mid_load");
        stim_b = {8'hA5, 8'($urandom_range(0, 255)), 8'hA6, 8'($urandom_range(0, 255))};
        stim_l = {1'b0, 1'b0, 1'b0, 1'b1};
        load_stream("reload", 2);
        cpu_read(8'h00); cpu_read(8'h01); cpu_read(8'h02);

        // Gapped stream, ld_last on a high byte has no effect.
        do_reset("pre_gapped");
        set_stream1(1'b1);
        load_stream("gapped", 3);
        cpu_read(8'h00); cpu_read(8'h01); cpu_read(8'h02);

        // Loader may write protected addresses.
        do_reset("pre_lowload");
        stim_b.delete(); stim_l.delete();
        for (int i = 0; i < 34; i++) begin
            stim_b.push_back(8'($urandom_range(0, 255)));
            stim_l.push_back(i == 33);
        end
        load_stream("lowload", 2);
        cpu_read(8'h10); cpu_read(8'h00);
        cpu_write(8'h10, 16'h1234);
        cpu_read(8'h10);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge ck);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
